// File: rtl/huffman_dec_pack.sv
// Serial Huffman decoder with a programmable code table. Decoded symbols are
// packed into rows of NUM_WORDS words; slot 0 sits in out[BW-1:0].
//
// Handshakes (both valid/ready; a transfer happens on a rising edge where
// both are high):
//   input  side: valid_in/in_ready. One bit moves when valid_in && in_ready.
//   output side: valid/out_ready. One row moves when valid && out_ready.
//                While valid && !out_ready, out and valid hold and
//                in_ready stays low.
module huffman_dec_pack #(
  parameter int BW        = 4,
  parameter int NUM_WORDS = 8,
  parameter int MAX_LEN   = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cfg_we,
  input  logic [BW-1:0]                 cfg_sym,
  input  logic [MAX_LEN-1:0]            cfg_code,
  input  logic [$clog2(MAX_LEN+1)-1:0]  cfg_len,
  input  logic                          valid_in,
  input  logic                          in,
  output logic                          in_ready,
  input  logic                          flush,
  output logic [BW*NUM_WORDS-1:0]       out,
  output logic                          valid,
  input  logic                          out_ready,
  output logic                          err
);

  localparam int NSYM = 2 ** BW;
  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int PW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int SW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int RW   = BW * NUM_WORDS;

  // Code table: len 0 means the entry never matches.
  logic [MAX_LEN-1:0] code_q [NSYM];
  logic [LW-1:0]      len_q  [NSYM];

  logic [MAX_LEN-2:0] sreg_q, sreg_d;
  logic [PW-1:0]      plen_q, plen_d;
  logic [SW-1:0]      slot_cnt_q, slot_cnt_d;
  logic [RW-1:0]      row_q, row_d;
  logic [RW-1:0]      out_q, out_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic [LW-1:0]      plen1;
  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic               match_any;
  logic [BW-1:0]      match_sym;

  logic               accept, hit, bad, flush_take, full, emit;
  logic [RW-1:0]      row_fill;

  assign in_ready = !valid_q || out_ready;
  assign out      = out_q;
  assign valid    = valid_q;
  assign err      = err_q;

  // Candidate match against the table; scanning downward leaves the lowest
  // matching symbol index as the winner.
  always_comb begin
    plen1     = LW'(plen_q) + LW'(1);
    cand      = {sreg_q, in};
    mask      = ~({MAX_LEN{1'b1}} << plen1);
    match_any = 1'b0;
    match_sym = '0;
    for (int s = NSYM - 1; s >= 0; s--) begin
      if ((len_q[s] == plen1) && ((cand & mask) == (code_q[s] & mask))) begin
        match_any = 1'b1;
        match_sym = BW'(s);
      end
    end
  end

  // Next-state for decode, packing, flush and output row.
  always_comb begin
    accept     = valid_in && in_ready;
    hit        = accept && match_any;
    bad        = accept && !match_any && (plen1 == LW'(MAX_LEN));
    flush_take = flush && in_ready;

    row_fill = row_q;
    if (hit) row_fill[int'(slot_cnt_q)*BW +: BW] = match_sym;

    full = hit && (slot_cnt_q == SW'(NUM_WORDS - 1));
    emit = full || (flush_take && ((slot_cnt_q != '0) || hit));

    sreg_d     = sreg_q;
    plen_d     = plen_q;
    slot_cnt_d = slot_cnt_q;
    row_d      = row_q;
    out_d      = out_q;
    valid_d    = valid_q;
    err_d      = err_q;

    if (valid_q && out_ready) valid_d = 1'b0;

    if (hit) begin
      row_d      = row_fill;
      slot_cnt_d = slot_cnt_q + SW'(1);
      plen_d     = '0;
    end else if (bad) begin
      err_d  = 1'b1;
      plen_d = '0;
    end else if (accept) begin
      sreg_d = cand[MAX_LEN-2:0];
      plen_d = plen_q + PW'(1);
    end

    // A flush always abandons any partial prefix.
    if (flush_take) plen_d = '0;

    // Emission only happens when in_ready is high, so a held row is never
    // overwritten.
    if (emit) begin
      out_d      = row_fill;
      valid_d    = 1'b1;
      row_d      = '0;
      slot_cnt_d = '0;
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg_q     <= '0;
      plen_q     <= '0;
      slot_cnt_q <= '0;
      row_q      <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sreg_q     <= sreg_d;
      plen_q     <= plen_d;
      slot_cnt_q <= slot_cnt_d;
      row_q      <= row_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  // Table writes land on the edge, so a same-cycle decode sees the old entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NSYM; s++) begin
        code_q[s] <= '0;
        len_q[s]  <= '0;
      end
    end else if (cfg_we) begin
      code_q[cfg_sym] <= cfg_code;
      len_q[cfg_sym]  <= cfg_len;
    end
  end

endmodule

// File: tb/tb_huffman_dec_pack.sv
// Bench for huffman_dec_pack: directed scenarios plus a randomized phase,
// all checked against a symbol-level model kept here.
module tb_huffman_dec_pack;

  localparam int BW = 4;
  localparam int NW = 8;
  localparam int ML = 8;
  localparam int LW = 4;
  localparam int W  = BW * NW;

  logic          clk;
  logic          reset_n;
  logic          cfg_we;
  logic [BW-1:0] cfg_sym;
  logic [ML-1:0] cfg_code;
  logic [LW-1:0] cfg_len;
  logic          valid_in;
  logic          in_bit;
  logic          in_ready;
  logic          flush;
  logic [W-1:0]  out_row;
  logic          valid;
  logic          out_ready;
  logic          err;

  huffman_dec_pack #(.BW(BW), .NUM_WORDS(NW), .MAX_LEN(ML)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_sym(cfg_sym),
    .cfg_code(cfg_code), .cfg_len(cfg_len), .valid_in(valid_in), .in(in_bit),
    .in_ready(in_ready), .flush(flush), .out(out_row), .valid(valid),
    .out_ready(out_ready), .err(err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int dut_rows = 0;
  logic [W-1:0] dut_last = '0;
  bit rnd_ready = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int len_tab [16];
  int code_tab[16];
  int syms[$];
  int pend_val, pend_len;
  bit m_err;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] row_log[$];

  task automatic model_reset();
    for (int s = 0; s < 16; s++) begin len_tab[s] = 0; code_tab[s] = 0; end
    syms.delete(); exp_q.delete();
    pend_val = 0; pend_len = 0; m_err = 0;
  endtask

  task automatic model_emit();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < syms.size(); i++) r = r | (W'(syms[i]) << (BW * i));
    exp_q.push_back(r);
    row_log.push_back(r);
    syms.delete();
  endtask

  task automatic model_bit(input int b);
    int found;
    pend_val = (pend_val << 1) | b;
    pend_len++;
    found = -1;
    for (int s = 0; s < 16; s++)
      if (found < 0 && len_tab[s] == pend_len && code_tab[s] == pend_val) found = s;
    if (found >= 0) begin
      syms.push_back(found);
      pend_val = 0; pend_len = 0;
      if (syms.size() == NW) model_emit();
    end else if (pend_len == ML) begin
      m_err = 1;
      pend_val = 0; pend_len = 0;
    end
  endtask

  // Compare process: check outputs against the model, then advance the model
  // with what will happen on the coming rising edge.
  always @(negedge clk) begin
    bit m_valid, m_rdy;
    if (!reset_n) begin
      model_reset();
    end else begin
      m_valid = (exp_q.size() > 0);
      m_rdy   = !m_valid || out_ready;
      check("valid", W'(valid), W'(m_valid));
      check("in_ready", W'(in_ready), W'(m_rdy));
      check("err", W'(err), W'(m_err));
      if (m_valid) check("out", out_row, exp_q[0]);
      if (valid && out_ready) begin dut_rows++; dut_last = out_row; end
      if (m_valid && out_ready) void'(exp_q.pop_front());
      if (valid_in && m_rdy) model_bit(int'(in_bit));
      if (flush && m_rdy) begin
        if (syms.size() > 0) model_emit();
        pend_val = 0; pend_len = 0;
      end
      if (cfg_we) begin
        len_tab[cfg_sym]  = int'(cfg_len);
        code_tab[cfg_sym] = int'(cfg_code);
      end
    end
  end

  // ---------------- driver tasks (all end at posedge + 1) ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cfg_write(input int sym, input int code, input int len);
    cfg_we = 1; cfg_sym = BW'(sym); cfg_code = ML'(code); cfg_len = LW'(len);
    @(posedge clk); #1;
    cfg_we = 0;
  endtask

  task automatic load_std();
    cfg_write(0, 0, 1);
    cfg_write(1, 2, 2);
    cfg_write(2, 3, 2);
  endtask

  task automatic send_bit(input logic b);
    bit ok;
    int n;
    valid_in = 1; in_bit = b; n = 0;
    do begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      cfg_we = 0;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end while (!ok && n < 200);
    valid_in = 0;
    if (!ok) begin errors++; $display("FAIL send_bit timeout at %0t", $time); end
  endtask

  task automatic send_seq(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
  endtask

  task automatic do_flush();
    bit ok;
    int n;
    flush = 1; n = 0;
    do begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end while (!ok && n < 200);
    flush = 0;
    if (!ok) begin errors++; $display("FAIL flush timeout at %0t", $time); end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r0;
    reset_n = 0; cfg_we = 0; cfg_sym = '0; cfg_code = '0; cfg_len = '0;
    valid_in = 0; in_bit = 0; flush = 0; out_ready = 1;

    repeat (3) @(negedge clk);
    check("rst_valid", W'(valid), '0);
    check("rst_err", W'(err), '0);
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out", out_row, '0);
    @(posedge clk); #1;
    reset_n = 1;
    idle(1);
    load_std();

    // Eight '0' bits -> one all-zero row, single-cycle valid.
    r0 = dut_rows;
    send_seq(64'h0, 8);
    idle(3);
    check("s1_rows", W'(dut_rows - r0), W'(1));
    check("s1_out", dut_last, 32'h0000_0000);
    check("s1_model", row_log[$], 32'h0000_0000);
    check("s1_err", W'(err), '0);
    check("s1_valid_low", W'(valid), '0);

    // Mixed codes: 0 | 10 | 11 | 0 x5.
    send_seq(64'b0101100000, 10);
    idle(3);
    check("s2_out", dut_last, 32'h0000_0210);
    check("s2_model", row_log[$], 32'h0000_0210);

    // Back-pressure: full row held while the consumer stalls.
    out_ready = 0;
    r0 = dut_rows;
    send_seq(64'hAAAA, 16);
    valid_in = 1; in_bit = 1;
    repeat (10) begin
      @(negedge clk);
      check("s3_in_ready", W'(in_ready), '0);
      check("s3_valid", W'(valid), W'(1));
      check("s3_hold", out_row, 32'h1111_1111);
    end
    @(posedge clk); #1;
    out_ready = 1;
    send_seq(64'b10101, 5);
    idle(3);
    check("s3_rows", W'(dut_rows - r0), W'(1));
    check("s3_out", dut_last, 32'h1111_1111);
    do_flush();
    idle(2);
    check("s3_flush_out", dut_last, 32'h0000_0011);
    check("s3_flush_model", row_log[$], 32'h0000_0011);

    // Partial row flush, then an empty flush.
    send_seq(64'b101110, 6);
    flush = 1;
    @(negedge clk);
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    check("s4_valid", W'(valid), W'(1));
    check("s4_out", out_row, 32'h0000_0121);
    @(posedge clk); #1;
    r0 = dut_rows;
    do_flush();
    idle(4);
    check("s4_empty_flush", W'(dut_rows - r0), '0);

    // Only "00" defined: eight '1' bits trip the sticky error.
    cfg_write(0, 0, 2);
    cfg_write(1, 0, 0);
    cfg_write(2, 0, 0);
    r0 = dut_rows;
    send_seq(64'hFF, 8);
    idle(2);
    check("s5_err", W'(err), W'(1));
    check("s5_no_row", W'(dut_rows - r0), '0);
    send_seq(64'h0, 16);
    idle(3);
    check("s5_rows", W'(dut_rows - r0), W'(1));
    check("s5_out", dut_last, 32'h0000_0000);
    check("s5_err_sticky", W'(err), W'(1));

    // Reset mid-row discards partial data and the table.
    load_std();
    send_seq(64'b000, 3);
    @(posedge clk); #3;
    reset_n = 0;
    @(negedge clk);
    check("s6_rst_valid", W'(valid), '0);
    check("s6_rst_err", W'(err), '0);
    check("s6_rst_in_ready", W'(in_ready), W'(1));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    load_std();
    r0 = dut_rows;
    send_seq(64'h0, 8);
    idle(5);
    check("s6_rows", W'(dut_rows - r0), W'(1));
    check("s6_out", dut_last, 32'h0000_0000);
    check("s6_err", W'(err), '0);

    // Randomized traffic with stalls, flushes and same-cycle table writes.
    rnd_ready = 1;
    for (int i = 0; i < 600; i++) begin
      int pick;
      pick = $urandom_range(0, 39);
      if (pick == 0) do_flush();
      else if (pick == 1) idle(1);
      else begin
        if (pick == 2) begin
          cfg_we = 1; cfg_sym = '0;
          cfg_code = ML'($urandom_range(0, 1)); cfg_len = LW'(1);
        end
        send_bit(1'($urandom_range(0, 1)));
      end
    end
    rnd_ready = 0;
    out_ready = 1;
    do_flush();
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/huffman_dec_pack.md
HUFFMAN_DEC_PACK -- requirements
Module: huffman_dec_pack

Interface
REQ-001 The block SHALL expose parameter BW, default 4, giving the bits per decoded word and symbol.
REQ-002 The block SHALL expose parameter NUM_WORDS, default 8, giving the words per output row.
REQ-003 The block SHALL expose parameter MAX_LEN, default 8, giving the maximum code length in bits.
REQ-004 The block SHALL have port clk, input, 1 bit, the only clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port cfg_we, input, 1 bit, the code-table write strobe.
REQ-007 The block SHALL have port cfg_sym, input, BW bits, the table entry (symbol value) being written.
REQ-008 The block SHALL have port cfg_code, input, MAX_LEN bits, the code right-aligned; the first-received bit is bit cfg_len-1.
REQ-009 The block SHALL have port cfg_len, input, $clog2(MAX_LEN+1) bits, the code length; 0 marks the symbol unused.
REQ-010 The block SHALL have port valid_in, input, 1 bit, meaning bit "in" is offered.
REQ-011 The block SHALL have port in, input, 1 bit, the serial encoded bit.
REQ-012 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts the bit this cycle.
REQ-013 The block SHALL have port flush, input, 1 bit, requesting emission of a partial row.
REQ-014 The block SHALL have port out, output, BW*NUM_WORDS bits; the first decoded word of a row is in bits [BW-1:0].
REQ-015 The block SHALL have port valid, output, 1 bit, meaning the row on out is valid.
REQ-016 The block SHALL have port out_ready, input, 1 bit, the consumer accepting the row.
REQ-017 The block SHALL have port err, output, 1 bit, a sticky decode-error flag.

Function
REQ-018 A bit SHALL be accepted only in a cycle where valid_in && in_ready; in_ready SHALL equal !valid || out_ready.
REQ-019 The block SHALL hold accumulated prefix bits sreg and count plen; an accepted bit forms candidate {sreg,in} with length plen+1.
REQ-020 The candidate SHALL match entry s when table len[s]==plen+1 and the low plen+1 bits equal code[s]; matching is combinational within the cycle.
REQ-021 If several entries match, the lowest symbol index SHALL win.
REQ-022 On a match, symbol s SHALL be written into slot slot_cnt of the row buffer, slot_cnt SHALL increment, and plen SHALL clear.
REQ-023 With no match and plen+1==MAX_LEN, err SHALL set and remain set until reset, plen SHALL clear and the bits SHALL be discarded.
REQ-024 With no match and plen+1<MAX_LEN, the bit SHALL be shifted into sreg and plen SHALL increment.
REQ-025 When the decode that fills slot NUM_WORDS-1 occurs, the full row SHALL be loaded into out with valid=1 on the next edge and slot_cnt SHALL wrap to 0; latency is 1 cycle from the completing bit.
REQ-026 While valid && !out_ready, out and valid SHALL be held stable and no bits SHALL be consumed.
REQ-027 On valid && out_ready, valid SHALL clear unless a new row loads on the same edge, in which case valid stays 1 with new data.
REQ-028 On flush && in_ready with slot_cnt>0, or a decode occurring in the same cycle, the row SHALL be emitted with any symbol decoded that cycle included first and unfilled slots zero.
REQ-029 On such a flush, slot_cnt and plen SHALL clear; discarded partial prefix bits SHALL NOT set err.
REQ-030 A flush with slot_cnt==0 and no decode that cycle SHALL emit nothing and SHALL clear plen.
REQ-031 A cfg_we write SHALL take effect from the next edge; a decode in the same cycle SHALL use the old table.
REQ-032 cfg_we SHALL be accepted regardless of in_ready.

Reset
REQ-033 On reset_n=0 the block SHALL asynchronously clear valid, err, out, slot_cnt, plen, sreg and every table len; in_ready SHALL then read 1.
REQ-034 A reset mid-row or mid-code SHALL discard all partial data; the table SHALL be reloaded by cfg writes after reset.

Verification (BW=4, NUM_WORDS=8, MAX_LEN=8; table sym0="0"/1, sym1="10"/2, sym2="11"/2)
REQ-035 The bench SHALL drive eight '0' bits with out_ready=1 and require valid=1 for 1 cycle, out=32'h00000000, err=0.
REQ-036 The bench SHALL drive bits 0,1,0,1,1,0,0,0,0,0 and require out=32'h00000210.
REQ-037 The bench SHALL drive "10" x8 with out_ready=0, then 5 more bits, and require out=32'h11111111 held, in_ready=0, and no bits consumed until out_ready=1.
REQ-038 The bench SHALL drive 1,0,1,1,1,0 then flush and require out=32'h00000121 and valid=1 next cycle; a second flush SHALL produce no output.
REQ-039 The bench SHALL load only sym0="00"/2, drive eight '1' bits, and require err=1 sticky, no valid, and then a subsequent "00" x8 producing a valid all-zero row.
REQ-040 The bench SHALL pull reset_n low after 3 symbols, then release it, reload the table, drive eight '0' bits, and require exactly one row of 32'h00000000.
